hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight writers in EX/MEM/WB and produces
// stall, flush and forwarding controls for a 5-stage in-order pipeline.
module hazard_scoreboard #(
  parameter int unsigned REGW    = 5,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned FWD_EN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_d,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic            use_rs1_d,
  input  logic            use_rs2_d,
  input  logic [REGW-1:0] rd_d,
  input  logic            regwrite_d,
  input  logic            load_d,
  input  logic            pcsrc_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            stall_m,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_w,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            mem_busy
);

  localparam logic       FwdOn   = (FWD_EN != 0);
  localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

  logic            e_valid_q, e_valid_d;
  logic [REGW-1:0] e_rd_q, e_rd_d;
  logic            e_load_q, e_load_d;
  logic [REGW-1:0] e_rs1_q, e_rs1_d;
  logic [REGW-1:0] e_rs2_q, e_rs2_d;
  logic            e_use_rs1_q, e_use_rs1_d;
  logic            e_use_rs2_q, e_use_rs2_d;
  logic            m_valid_q, m_valid_d;
  logic [REGW-1:0] m_rd_q, m_rd_d;
  logic            m_load_q, m_load_d;
  logic            w_valid_q, w_valid_d;
  logic [REGW-1:0] w_rd_q, w_rd_d;
  logic [3:0]      cnt_q, cnt_d;

  logic       freeze, load_use, raw, hazard;
  logic       flush_id, flush_ex, stall_front, accept;
  logic [1:0] fwd_a, fwd_b;

  // A used, non-zero source index matching a live writer's destination.
  function automatic logic src_hit(input logic            use_src,
                                   input logic [REGW-1:0] src,
                                   input logic            ent_valid,
                                   input logic [REGW-1:0] ent_rd);
    return use_src & (src != '0) & ent_valid & (src == ent_rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic            use_src,
                                         input logic [REGW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (FwdOn && use_src && (src != '0)) begin
      if (m_valid_q && !m_load_q && (m_rd_q == src)) begin
        sel = 2'b10;
      end else if (w_valid_q && (w_rd_q == src)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_comb begin
    freeze   = m_valid_q & m_load_q & (cnt_q != LastCnt);
    load_use = valid_d & e_load_q &
               (src_hit(use_rs1_d, rs1_d, e_valid_q, e_rd_q) |
                src_hit(use_rs2_d, rs2_d, e_valid_q, e_rd_q));
    raw      = valid_d &
               (src_hit(use_rs1_d, rs1_d, e_valid_q, e_rd_q) |
                src_hit(use_rs2_d, rs2_d, e_valid_q, e_rd_q) |
                src_hit(use_rs1_d, rs1_d, m_valid_q, m_rd_q) |
                src_hit(use_rs2_d, rs2_d, m_valid_q, m_rd_q) |
                src_hit(use_rs1_d, rs1_d, w_valid_q, w_rd_q) |
                src_hit(use_rs2_d, rs2_d, w_valid_q, w_rd_q));
    hazard   = FwdOn ? load_use : raw;
    // A taken branch kills the stalled instruction, so the stall is dropped.
    flush_id    = ~freeze & pcsrc_e;
    flush_ex    = ~freeze & (hazard | pcsrc_e);
    stall_front = freeze | (hazard & ~flush_id);
    accept      = valid_d & ~stall_front & ~flush_ex;
    fwd_a       = fwd_sel(e_use_rs1_q, e_rs1_q);
    fwd_b       = fwd_sel(e_use_rs2_q, e_rs2_q);
  end

  always_comb begin
    e_valid_d   = e_valid_q;
    e_rd_d      = e_rd_q;
    e_load_d    = e_load_q;
    e_rs1_d     = e_rs1_q;
    e_rs2_d     = e_rs2_q;
    e_use_rs1_d = e_use_rs1_q;
    e_use_rs2_d = e_use_rs2_q;
    m_valid_d   = m_valid_q;
    m_rd_d      = m_rd_q;
    m_load_d    = m_load_q;
    w_valid_d   = w_valid_q;
    w_rd_d      = w_rd_q;
    cnt_d       = cnt_q;
    if (freeze) begin
      // E and M hold; a bubble drains into W while the load waits.
      w_valid_d = 1'b0;
      cnt_d     = cnt_q + 4'd1;
    end else begin
      w_valid_d   = m_valid_q;
      w_rd_d      = m_rd_q;
      m_valid_d   = e_valid_q;
      m_rd_d      = e_rd_q;
      m_load_d    = e_load_q;
      cnt_d       = 4'd0;
      e_valid_d   = accept & regwrite_d & (rd_d != '0);
      e_rd_d      = rd_d;
      e_load_d    = accept & regwrite_d & (rd_d != '0) & load_d;
      e_rs1_d     = rs1_d;
      e_rs2_d     = rs2_d;
      e_use_rs1_d = accept & use_rs1_d;
      e_use_rs2_d = accept & use_rs2_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid_q   <= 1'b0;
      e_rd_q      <= '0;
      e_load_q    <= 1'b0;
      e_rs1_q     <= '0;
      e_rs2_q     <= '0;
      e_use_rs1_q <= 1'b0;
      e_use_rs2_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_rd_q      <= '0;
      m_load_q    <= 1'b0;
      w_valid_q   <= 1'b0;
      w_rd_q      <= '0;
      cnt_q       <= 4'd0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_rd_q      <= e_rd_d;
      e_load_q    <= e_load_d;
      e_rs1_q     <= e_rs1_d;
      e_rs2_q     <= e_rs2_d;
      e_use_rs1_q <= e_use_rs1_d;
      e_use_rs2_q <= e_use_rs2_d;
      m_valid_q   <= m_valid_d;
      m_rd_q      <= m_rd_d;
      m_load_q    <= m_load_d;
      w_valid_q   <= w_valid_d;
      w_rd_q      <= w_rd_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs are forced low for as long as reset is held, independent of inputs.
  assign stall_f  = rst & stall_front;
  assign stall_d  = rst & stall_front;
  assign stall_e  = rst & freeze;
  assign stall_m  = rst & freeze;
  assign flush_d  = rst & flush_id;
  assign flush_e  = rst & flush_ex;
  assign flush_w  = rst & freeze;
  assign fwd_a_e  = {2{rst}} & fwd_a;
  assign fwd_b_e  = {2{rst}} & fwd_b;
  assign mem_busy = rst & freeze;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one stimulus stream and are
// compared every cycle against an instruction-level pipeline model.
module tb_hazard_scoreboard;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_d, use_rs1_d, use_rs2_d, regwrite_d, load_d, pcsrc_e;
  logic [4:0] rs1_d, rs2_d, rd_d;

  logic       sf[NDUT], sd[NDUT], se[NDUT], sm[NDUT];
  logic       fd[NDUT], fe[NDUT], fw[NDUT], mb[NDUT];
  logic [1:0] fa[NDUT], fb[NDUT];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REGW(5), .MEM_LAT(1), .FWD_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
    .load_d(load_d), .pcsrc_e(pcsrc_e), .stall_f(sf[0]), .stall_d(sd[0]), .stall_e(se[0]),
    .stall_m(sm[0]), .flush_d(fd[0]), .flush_e(fe[0]), .flush_w(fw[0]), .fwd_a_e(fa[0]),
    .fwd_b_e(fb[0]), .mem_busy(mb[0]));

  hazard_scoreboard #(.REGW(5), .MEM_LAT(4), .FWD_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
    .load_d(load_d), .pcsrc_e(pcsrc_e), .stall_f(sf[1]), .stall_d(sd[1]), .stall_e(se[1]),
    .stall_m(sm[1]), .flush_d(fd[1]), .flush_e(fe[1]), .flush_w(fw[1]), .fwd_a_e(fa[1]),
    .fwd_b_e(fb[1]), .mem_busy(mb[1]));

  hazard_scoreboard #(.REGW(5), .MEM_LAT(1), .FWD_EN(0)) u_dut2 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
    .load_d(load_d), .pcsrc_e(pcsrc_e), .stall_f(sf[2]), .stall_d(sd[2]), .stall_e(se[2]),
    .stall_m(sm[2]), .flush_d(fd[2]), .flush_e(fe[2]), .flush_w(fw[2]), .fwd_a_e(fa[2]),
    .fwd_b_e(fb[2]), .mem_busy(mb[2]));

  // Reference model: the instruction sitting in each of EX, MEM, WB.
  typedef struct packed {
    logic       wr;   // writes a non-zero register
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } instr_t;

  instr_t ex_i[NDUT], mem_i[NDUT], wb_i[NDUT];
  int     waited[NDUT];  // cycles the instruction in MEM has already spent there

  function automatic int lat_of(input int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic bit fwd_of(input int k);
    return (k != 2);
  endfunction

  function automatic bit reads(input logic used, input logic [4:0] src, input instr_t p);
    return used && (src != 0) && p.wr && (src == p.rd);
  endfunction

  function automatic logic [1:0] pick(input int k, input logic used, input logic [4:0] src);
    if (!fwd_of(k) || !used || src == 0) return 2'b00;
    if (mem_i[k].wr && !mem_i[k].ld && mem_i[k].rd == src) return 2'b10;
    if (wb_i[k].wr && wb_i[k].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Packed: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fa, fb, busy}
  function automatic logic [11:0] model_out(input int k);
    bit         busy, haz;
    logic [1:0] a, b;
    if (!rst) return 12'h000;
    busy = mem_i[k].wr && mem_i[k].ld && (waited[k] + 1 < lat_of(k));
    if (fwd_of(k))
      haz = valid_d && ex_i[k].ld &&
            (reads(use_rs1_d, rs1_d, ex_i[k]) || reads(use_rs2_d, rs2_d, ex_i[k]));
    else
      haz = valid_d &&
            (reads(use_rs1_d, rs1_d, ex_i[k]) || reads(use_rs2_d, rs2_d, ex_i[k]) ||
             reads(use_rs1_d, rs1_d, mem_i[k]) || reads(use_rs2_d, rs2_d, mem_i[k]) ||
             reads(use_rs1_d, rs1_d, wb_i[k]) || reads(use_rs2_d, rs2_d, wb_i[k]));
    a = pick(k, ex_i[k].u1, ex_i[k].rs1);
    b = pick(k, ex_i[k].u2, ex_i[k].rs2);
    if (busy) return {7'b1111001, a, b, 1'b1};
    return {haz && !pcsrc_e, haz && !pcsrc_e, 2'b00, pcsrc_e, haz || pcsrc_e, 1'b0, a, b,
            1'b0};
  endfunction

  function automatic logic [11:0] obs(input int k);
    return {sf[k], sd[k], se[k], sm[k], fd[k], fe[k], fw[k], fa[k], fb[k], mb[k]};
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NDUT; k++) begin
      ex_i[k] = '0; mem_i[k] = '0; wb_i[k] = '0; waited[k] = 0;
    end
  endtask

  task automatic drive(input logic v, input int r1, input logic u1, input int r2,
                       input logic u2, input int rd, input logic rw, input logic ld,
                       input logic pc);
    valid_d = v; rs1_d = 5'(r1); use_rs1_d = u1; rs2_d = 5'(r2); use_rs2_d = u2;
    rd_d = 5'(rd); regwrite_d = rw; load_d = ld; pcsrc_e = pc;
  endtask

  task automatic nop();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("dut%0d_cyc%0d", k, cyc), obs(k), model_out(k));
  endtask

  task automatic advance();
    instr_t     ne[NDUT], nm[NDUT], nw[NDUT], dec;
    int         nwait[NDUT];
    logic [11:0] o;
    dec = '{wr: regwrite_d && rd_d != 0, ld: regwrite_d && rd_d != 0 && load_d, rd: rd_d,
            rs1: rs1_d, rs2: rs2_d, u1: use_rs1_d, u2: use_rs2_d};
    for (int k = 0; k < NDUT; k++) begin
      o = model_out(k);
      if (o[0]) begin
        ne[k] = ex_i[k]; nm[k] = mem_i[k]; nw[k] = '0; nwait[k] = waited[k] + 1;
      end else begin
        nw[k] = mem_i[k]; nm[k] = ex_i[k]; nwait[k] = 0;
        ne[k] = (valid_d && !o[10] && !o[6]) ? dec : '0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      for (int k = 0; k < NDUT; k++) begin
        ex_i[k] = ne[k]; mem_i[k] = nm[k]; wb_i[k] = nw[k]; waited[k] = nwait[k];
      end
    end else begin
      model_clear();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < NDUT; k++) chk($sformatf("rst_zero%0d", k), obs(k), 0);
    nop();
    @(posedge clk);
    #1;
    sample();
    rst = 1'b1;
    advance();
  endtask

  int n_busy, n_stm, n_std;

  initial begin
    nop();
    model_clear();
    do_reset();

    // add x5 then dependent sub x6,x5: ALU result forwarded from MEM, no stall
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); sample(); advance();
    drive(1, 5, 1, 3, 1, 6, 1, 0, 0); sample();
    chk("fwd_nostall", sd[0], 0);
    advance();
    nop(); sample();
    chk("fwd_a_mem", fa[0], 2'b10);
    chk("fwd_b_none", fb[0], 2'b00);
    advance();

    // lw x7 then add using x7 (MEM_LAT=1): one stall cycle, then WB forward
    do_reset();
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0); sample(); advance();
    drive(1, 7, 1, 2, 1, 8, 1, 0, 0); sample();
    chk("lu_stall", {sf[0], sd[0], fe[0]}, 3'b111);
    advance();
    sample();
    chk("lu_release", sd[0], 0);
    advance();
    nop(); sample();
    chk("lu_fwd_wb", fa[0], 2'b01);
    advance();

    // lw with MEM_LAT=4: three busy cycles, consumer then forwarded from WB
    do_reset();
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0); sample(); advance();
    n_busy = 0; n_stm = 0;
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      sample();
      n_busy += int'(mb[1]);
      n_stm  += int'(sm[1]);
      advance();
    end
    chk("lat4_busy_cycles", n_busy, 3);
    chk("lat4_stallm_cycles", n_stm, 3);
    nop(); sample();
    chk("lat4_fwd_wb", fa[1], 2'b01);
    advance();

    // branch taken during load-use stall, then during mem_busy
    do_reset();
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0); sample(); advance();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 1); sample();
    chk("br_over_stall", {fd[0], fe[0], sd[0], sf[0]}, 4'b1100);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); sample();
    chk("br_in_busy", {mb[1], fd[1], fe[1], sf[1]}, 4'b1001);
    advance();

    // no forwarding: RAW stall until producer leaves WB; x0 producer never stalls
    do_reset();
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); sample(); advance();
    n_std = 0;
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      sample();
      n_std += int'(sd[2]);
      advance();
    end
    chk("raw_stall_cycles", n_std, 3);
    nop(); sample();
    chk("nofwd_fwd_a", fa[2], 2'b00);
    advance();
    drive(1, 1, 1, 2, 1, 0, 1, 0, 0); sample(); advance();
    drive(1, 0, 1, 0, 1, 9, 1, 0, 0); sample();
    chk("x0_nostall", sd[2], 0);
    advance();

    // reset while the load is waiting in MEM
    do_reset();
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0); sample(); advance();
    nop(); sample(); advance();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 1); sample();
    chk("pre_rst_busy", {mb[1], sf[1]}, 2'b11);
    do_reset();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0); sample();
    chk("post_rst_clean", {sd[1], mb[1]}, 2'b00);
    advance();

    // randomized traffic over a small register window
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
              $urandom_range(0, 9) == 0);
        sample();
        advance();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
